// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode and FSM state types for alu_exec_unit
package alu_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 4;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL} op_t;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: 8-step shift-add multiplier; load captures a/b, step adds one partial product, last flags all steps taken
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] prod,
  output logic            last
);
  logic [2*DW-1:0] acc, mcand;
  logic [DW-1:0]   mplier;
  logic [2:0]      cnt;
  logic            full;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{DW{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      full   <= 1'b0;
    end else if (step && !full) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 3'd1;
      full   <= cnt == 3'd7;
    end
  end
  assign prod = acc;
  assign last = full;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage reading two reg_file operands, running one ALU op (MUL sequential) and writing back with flags
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] dst,
  output logic [AW-1:0] rd_addr1,
  output logic [AW-1:0] rd_addr2,
  input  logic [DW-1:0] val1_in,
  input  logic [DW-1:0] val2_in,
  output logic          write_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] val_out,
  output logic          busy,
  output logic          done,
  output logic          carry,
  output logic          zero
);
  state_t state, nxt;
  op_t op_q;
  logic [AW-1:0] s1_q, s2_q, dst_q;
  logic [DW-1:0] a_q, b_q, res;
  logic [2*DW-1:0] prod;
  logic [DW:0] sum, shl, shr;
  logic last, accept, c_res;
  assign accept = state == IDLE && start;
  always_comb nxt = state == IDLE ? (start ? (op == OP_MUL ? MUL : WB) : IDLE)
                  : state == MUL  ? (last ? WB : MUL) : IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_ADD;
      s1_q  <= '0;
      s2_q  <= '0;
      dst_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q  <= op_t'(op);
        s1_q  <= src1;
        s2_q  <= src2;
        dst_q <= dst;
        a_q   <= val1_in;
        b_q   <= val2_in;
      end
      if (state == WB) begin
        carry <= c_res;
        zero  <= res == '0;
      end
    end
  end
  shift_add_mul #(.DW(DW)) u_mul (
    .clk(clk), .reset(reset), .load(accept), .step(state == MUL),
    .a(val1_in), .b(val2_in), .prod(prod), .last(last)
  );
  // The shifted-out bit lands in the extra bit of these widened shifts; a zero shift leaves it 0.
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign shl = {1'b0, a_q} << b_q[2:0];
  assign shr = {a_q, 1'b0} >> b_q[2:0];
  always_comb begin
    res   = '0;
    c_res = 1'b0;
    case (op_q)
      OP_ADD: {c_res, res} = sum;
      OP_SUB: begin res = a_q - b_q; c_res = a_q < b_q; end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SHL: {c_res, res} = shl;
      OP_SHR: {res, c_res} = shr;
      OP_MUL: begin res = prod[DW-1:0]; c_res = |prod[2*DW-1:DW]; end
    endcase
  end
  assign busy     = state != IDLE;
  assign write_en = state == WB;
  assign done     = write_en;
  assign wr_addr  = write_en ? dst_q : '0;
  assign val_out  = write_en ? res : '0;
  assign rd_addr1 = state == IDLE ? src1 : s1_q;
  assign rd_addr2 = state == IDLE ? src2 : s2_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed bench with reg_file model, cycle-level behavioural reference and literal pins
module tb_alu_exec_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] src1 = '0, src2 = '0, dst = '0;
  logic [3:0] rd_addr1, rd_addr2, wr_addr;
  logic [7:0] val1_in, val2_in, val_out;
  logic write_en, busy, done, carry, zero;
  logic [7:0] rf [16];
  logic [7:0] mrf [16];
  int checks = 0, errors = 0, writes = 0;
  int m_left = 0;
  logic [3:0] m_dst = '0, m_s1 = '0, m_s2 = '0;
  logic [7:0] m_res = '0;
  logic m_c = 1'b0, m_cf = 1'b0, m_zf = 1'b0;
  int wcyc, bcnt, w0;
  always #5 clk = ~clk;
  alu_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2), .dst(dst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .val1_in(val1_in), .val2_in(val2_in),
    .write_en(write_en), .wr_addr(wr_addr), .val_out(val_out), .busy(busy), .done(done),
    .carry(carry), .zero(zero)
  );
  assign val1_in = rf[rd_addr1];
  assign val2_in = rf[rd_addr2];
  always @(posedge clk) if (write_en) begin
    rf[wr_addr] <= val_out;
    writes++;
  end
  function automatic logic [8:0] model_op(input int o, input int a, input int b);
    int r, s;
    logic c;
    s = b % 8;
    c = 1'b0;
    r = 0;
    case (o)
      0: begin r = a + b; c = r > 255; end
      1: begin r = a - b; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * (1 << s); c = s > 0 && ((a >> (8 - s)) & 1) != 0; end
      6: begin r = a >> s; c = s > 0 && ((a >> (s - 1)) & 1) != 0; end
      default: begin r = a * b; c = r > 255; end
    endcase
    return {c, 8'(r & 255)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a command occupies 1 cycle (10 for MUL) after acceptance, writing in its final cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_cf   <= 1'b0;
      m_zf   <= 1'b0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_cf <= m_c;
        m_zf <= m_res == 8'd0;
        mrf[m_dst] <= m_res;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      m_left <= op == 3'd7 ? 10 : 1;
      m_dst  <= dst;
      m_s1   <= src1;
      m_s2   <= src2;
      {m_c, m_res} <= model_op(int'(op), int'(mrf[src1]), int'(mrf[src2]));
    end
  end
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("write_en", 32'(write_en), 32'(m_left == 1));
    chk("done", 32'(done), 32'(m_left == 1));
    chk("wr_addr", 32'(wr_addr), 32'(m_left == 1 ? m_dst : 4'd0));
    chk("val_out", 32'(val_out), 32'(m_left == 1 ? m_res : 8'd0));
    chk("carry", 32'(carry), 32'(m_cf));
    chk("zero", 32'(zero), 32'(m_zf));
    chk("rd_addr1", 32'(rd_addr1), 32'(m_left == 0 ? src1 : m_s1));
    chk("rd_addr2", 32'(rd_addr2), 32'(m_left == 0 ? src2 : m_s2));
  end
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    @(posedge clk); #2;
    start = 1'b1; op = o; src1 = a; src2 = b; dst = d;
    @(posedge clk); #2;
    start = 1'b0;
  endtask
  task automatic settle;
    int n = 0;
    while (busy && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  task automatic run(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                     input logic [7:0] ev, input logic ec);
    issue(o, a, b, d);
    @(negedge clk);
    chk("lit_we", 32'(write_en), 32'd1);
    chk("lit_done", 32'(done), 32'd1);
    chk("lit_addr", 32'(wr_addr), 32'(d));
    chk("lit_val", 32'(val_out), 32'(ev));
    @(posedge clk); #2;
    chk("lit_we_low", 32'(write_en), 32'd0);
    chk("lit_carry", 32'(carry), 32'(ec));
    chk("lit_zero", 32'(zero), 32'(ev == 8'd0));
    chk("lit_rf", 32'(rf[d]), 32'(ev));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'd0;
      mrf[i] = 8'd0;
    end
    rf[0] = 8'd34;  mrf[0] = 8'd34;
    rf[1] = 8'd10;  mrf[1] = 8'd10;
    rf[10] = 8'd200; mrf[10] = 8'd200;
    rf[11] = 8'd100; mrf[11] = 8'd100;
    rf[12] = 8'd8;  mrf[12] = 8'd8;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_val", 32'(val_out), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    reset = 1'b1;
    run(3'd0, 4'd0, 4'd1, 4'd2, 8'd44, 1'b0);
    run(3'd1, 4'd1, 4'd0, 4'd3, 8'd232, 1'b1);
    w0 = writes;
    @(posedge clk); #2;
    start = 1'b1; op = 3'd7; src1 = 4'd0; src2 = 4'd1; dst = 4'd4;
    @(posedge clk); #2;
    start = 1'b0;
    wcyc = 0;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        start = 1'b1; op = 3'd0; dst = 4'd5;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      if (busy) bcnt++;
      if (write_en) begin
        wcyc = i;
        break;
      end
      @(posedge clk); #2;
    end
    chk("mul_wcycle", 32'(wcyc), 32'd10);
    chk("mul_busy", 32'(bcnt), 32'd10);
    chk("mul_addr", 32'(wr_addr), 32'd4);
    chk("mul_val", 32'(val_out), 32'd84);
    @(posedge clk); #2;
    settle;
    chk("mul_carry", 32'(carry), 32'd1);
    chk("mul_rf", 32'(rf[4]), 32'd84);
    chk("ignored_rf", 32'(rf[5]), 32'd0);
    chk("one_write", 32'(writes - w0), 32'd1);
    issue(3'd7, 4'd0, 4'd1, 4'd7);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(write_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    chk("abort_rf", 32'(rf[7]), 32'd0);
    run(3'd0, 4'd0, 4'd1, 4'd8, 8'd44, 1'b0);
    run(3'd4, 4'd0, 4'd0, 4'd6, 8'd0, 1'b0);
    run(3'd5, 4'd0, 4'd1, 4'd9, 8'd136, 1'b0);
    run(3'd6, 4'd0, 4'd1, 4'd13, 8'd8, 1'b1);
    run(3'd0, 4'd10, 4'd11, 4'd14, 8'd44, 1'b1);
    run(3'd5, 4'd0, 4'd12, 4'd15, 8'd34, 1'b0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
